line_buffer_sched: RTL and testbench

Ping-pong scanline buffer scheduler between the sprite/tile line renderer and the pixel output path. Tracks the video timing generator's HPOS/VPOS/HBLK/VBLK and schedules the renderer one line ahead. Owns two line banks, swapping them at each line start, and serves the front bank to the mixer. Optionally clears each pixel after it is read. Detects renderer overruns and reports them.

---
 rtl/line_buffer_sched.sv | 138 +++++++++++++
 tb/tb_line_buffer_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_sched.sv
// Ping-pong scanline buffer scheduler: swaps two line banks at each line start and schedules the renderer one line ahead.
// Optional read-then-clear of the front bank is enabled by defining LBUF_CLEAR_EN.
`timescale 1ns/1ps
module line_buffer_sched #(
  parameter int PIX_W     = 11,
  parameter int VIS_LINES = 224,
  parameter int LINE_LEN  = 256
) (
  input  logic             PCLK,
  input  logic             RSTn,
  input  logic [8:0]       HPOS,
  input  logic [8:0]       VPOS,
  input  logic             HBLK,
  input  logic             VBLK,
  output logic             RSTART,
  output logic [8:0]       RLINE,
  input  logic             RDONE,
  input  logic             WE,
  input  logic [7:0]       WADR,
  input  logic [PIX_W-1:0] WDAT,
  output logic [PIX_W-1:0] RDAT,
  output logic             BANK,
  output logic             LATE,
  output logic [7:0]       OVRCNT
);

  typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;

  localparam logic [9:0] VIS_LIM = 10'(VIS_LINES);

  state_t           state, state_nxt;
  logic             hblk_q;
  logic             ls;
  logic [8:0]       nxt_line;
  logic             start_nxt;
  logic             late_nxt;
  logic             rd_active;
  logic [7:0]       rd_adr;
  logic             ren_we;
  logic             clr_v;
  logic             clr_bank;
  logic [7:0]       clr_adr;
  logic [1:0]       wr_en;
  logic [7:0]       wr_adr [2];
  logic [PIX_W-1:0] wr_dat [2];
  logic [PIX_W-1:0] mem0 [LINE_LEN];
  logic [PIX_W-1:0] mem1 [LINE_LEN];
  logic             unused_ok;

  assign ls        = hblk_q & ~HBLK;
  assign nxt_line  = VPOS + 9'd1;
  assign rd_active = ~HBLK & ~VBLK;
  assign rd_adr    = HPOS[7:0];
  assign unused_ok = HPOS[8];
  // Writes landing on the swap edge belong to the bank that is about to be displayed, so drop them.
  assign ren_we    = WE && (state == BUSY) && !ls;

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    late_nxt  = 1'b0;
    if (ls) begin
      late_nxt = (state == BUSY) && !RDONE;
      if ({1'b0, nxt_line} < VIS_LIM) begin
        start_nxt = 1'b1;
        state_nxt = BUSY;
      end else begin
        state_nxt = IDLE;
      end
    end else if (state == BUSY && RDONE) begin
      state_nxt = READY;
    end
  end

  always_ff @(posedge PCLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= IDLE;
      hblk_q <= 1'b1;
      RSTART <= 1'b0;
      RLINE  <= '0;
      BANK   <= 1'b0;
      LATE   <= 1'b0;
      OVRCNT <= '0;
      RDAT   <= '0;
    end else begin
      state  <= state_nxt;
      hblk_q <= HBLK;
      RSTART <= start_nxt;
      LATE   <= late_nxt;
      if (start_nxt) RLINE <= nxt_line;
      if (ls) BANK <= ~BANK;
      if (late_nxt && OVRCNT != 8'hFF) OVRCNT <= OVRCNT + 8'd1;
      if (rd_active) RDAT <= BANK ? mem1[rd_adr] : mem0[rd_adr];
      else           RDAT <= '0;
    end
  end

`ifdef LBUF_CLEAR_EN
  // Remember which front-bank location was just read so it can be zeroed on the following edge.
  always_ff @(posedge PCLK or negedge RSTn) begin
    if (!RSTn) begin
      clr_v    <= 1'b0;
      clr_bank <= 1'b0;
      clr_adr  <= '0;
    end else begin
      clr_v    <= rd_active;
      clr_bank <= BANK;
      clr_adr  <= rd_adr;
    end
  end
`else
  assign clr_v    = 1'b0;
  assign clr_bank = 1'b0;
  assign clr_adr  = '0;
`endif

  // Renderer owns the back bank; a pending clear only wins when the renderer is not writing that bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      wr_en[b]  = 1'b0;
      wr_adr[b] = WADR;
      wr_dat[b] = WDAT;
      if (ren_we && (BANK != 1'(b))) begin
        wr_en[b] = 1'b1;
      end else if (clr_v && (clr_bank == 1'(b))) begin
        wr_en[b]  = 1'b1;
        wr_adr[b] = clr_adr;
        wr_dat[b] = '0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (wr_en[0]) mem0[wr_adr[0]] <= wr_dat[0];
    if (wr_en[1]) mem1[wr_adr[1]] <= wr_dat[1];
  end

endmodule

// File: tb/tb_line_buffer_sched.sv
// Scoreboard bench for line_buffer_sched: stimulus queues expected swap and readout results, a monitor pops and compares.
`timescale 1ns/1ps
module tb_line_buffer_sched;

  typedef struct {
    logic       bank;
    logic       rstart;
    logic [8:0] rline;
    logic       late;
    logic [7:0] ovr;
  } ls_t;

  logic        PCLK;
  logic        RSTn;
  logic [8:0]  HPOS;
  logic [8:0]  VPOS;
  logic        HBLK;
  logic        VBLK;
  logic        RSTART;
  logic [8:0]  RLINE;
  logic        RDONE;
  logic        WE;
  logic [7:0]  WADR;
  logic [10:0] WDAT;
  logic [10:0] RDAT;
  logic        BANK;
  logic        LATE;
  logic [7:0]  OVRCNT;

  int          checks = 0;
  int          errors = 0;
  ls_t         ls_q[$];
  logic [10:0] rd_q[$];
  logic        rd_chk = 1'b0;
  logic        rd_chk_q = 1'b0;
  logic        prev_bank = 1'b0;

  line_buffer_sched dut (
    .PCLK(PCLK), .RSTn(RSTn), .HPOS(HPOS), .VPOS(VPOS), .HBLK(HBLK), .VBLK(VBLK),
    .RSTART(RSTART), .RLINE(RLINE), .RDONE(RDONE), .WE(WE), .WADR(WADR), .WDAT(WDAT),
    .RDAT(RDAT), .BANK(BANK), .LATE(LATE), .OVRCNT(OVRCNT)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) rd_chk_q <= rd_chk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ls_t mk(input logic bank, input logic rstart, input logic [8:0] rline,
                             input logic late, input logic [7:0] ovr);
    ls_t e;
    e.bank = bank; e.rstart = rstart; e.rline = rline; e.late = late; e.ovr = ovr;
    return e;
  endfunction

  task automatic applyStimulus(input logic [8:0] hpos, input logic [8:0] vpos, input logic hblk,
                               input logic vblk, input logic we, input logic [7:0] wadr,
                               input logic [10:0] wdat, input logic rdone, input logic chk);
    HPOS = hpos; VPOS = vpos; HBLK = hblk; VBLK = vblk;
    WE = we; WADR = wadr; WDAT = wdat; RDONE = rdone; rd_chk = chk;
    @(posedge PCLK);
    #1;
  endtask

  // One blanking cycle (also checks blanked readout is zero) followed by the HBLK fall.
  task automatic lineStart(input logic [8:0] vpos, input logic rdone, input ls_t exp);
    rd_q.push_back(11'h000);
    applyStimulus(9'h010, vpos, 1'b1, 1'b0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b1);
    ls_q.push_back(exp);
    applyStimulus(9'h1FF, vpos, 1'b0, 1'b0, 1'b0, 8'h00, 11'h000, rdone, 1'b0);
  endtask

  always @(negedge PCLK) begin
    if (!RSTn) begin
      prev_bank = BANK;
    end else begin
      if (BANK !== prev_bank) begin
        if (ls_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_swap: got bank %0h expected no swap at %0t", BANK, $time);
        end else begin
          ls_t e;
          e = ls_q.pop_front();
          checkOutput("ls_bank", 32'(BANK), 32'(e.bank));
          checkOutput("ls_rstart", 32'(RSTART), 32'(e.rstart));
          checkOutput("ls_rline", 32'(RLINE), 32'(e.rline));
          checkOutput("ls_late", 32'(LATE), 32'(e.late));
          checkOutput("ls_ovrcnt", 32'(OVRCNT), 32'(e.ovr));
        end
      end else begin
        checkOutput("idle_rstart", 32'(RSTART), 32'd0);
        checkOutput("idle_late", 32'(LATE), 32'd0);
      end
      prev_bank = BANK;
      if (rd_chk_q) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rdat_queue: got rdat %0h expected queued value at %0t", RDAT, $time);
        end else begin
          checkOutput("rdat", 32'(RDAT), 32'(rd_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [10:0] second_read;
    RSTn = 1'b0; HPOS = '0; VPOS = '0; HBLK = 1'b1; VBLK = 1'b0;
    WE = 1'b0; WADR = '0; WDAT = '0; RDONE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    checkOutput("rst_rstart", 32'(RSTART), 32'd0);
    checkOutput("rst_rline", 32'(RLINE), 32'd0);
    checkOutput("rst_bank", 32'(BANK), 32'd0);
    checkOutput("rst_rdat", 32'(RDAT), 32'd0);
    checkOutput("rst_late", 32'(LATE), 32'd0);
    checkOutput("rst_ovrcnt", 32'(OVRCNT), 32'd0);
    RSTn = 1'b1;
    applyStimulus(9'h000, 9'd511, 1'b1, 1'b0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b0);

    lineStart(9'd511, 1'b0, mk(1'b1, 1'b1, 9'd0, 1'b0, 8'd0));
    applyStimulus(9'h020, 9'd511, 1'b0, 1'b0, 1'b1, 8'h10, 11'h2A5, 1'b0, 1'b0);
    applyStimulus(9'h021, 9'd511, 1'b0, 1'b0, 1'b0, 8'h00, 11'h000, 1'b1, 1'b0);
    applyStimulus(9'h022, 9'd511, 1'b0, 1'b0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b0);

    lineStart(9'd0, 1'b0, mk(1'b0, 1'b1, 9'd1, 1'b0, 8'd0));
    rd_q.push_back(11'h2A5);
    applyStimulus(9'h010, 9'd0, 1'b0, 1'b0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b1);
    rd_q.push_back(11'h000);
    applyStimulus(9'h010, 9'd0, 1'b0, 1'b1, 1'b0, 8'h00, 11'h000, 1'b0, 1'b1);

    lineStart(9'd1, 1'b0, mk(1'b1, 1'b1, 9'd2, 1'b1, 8'd1));
    repeat (3) applyStimulus(9'h040, 9'd1, 1'b0, 1'b0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b0);
    lineStart(9'd2, 1'b1, mk(1'b0, 1'b1, 9'd3, 1'b0, 8'd1));

`ifdef LBUF_CLEAR_EN
    second_read = 11'h000;
`else
    second_read = 11'h2A5;
`endif
    rd_q.push_back(second_read);
    applyStimulus(9'h010, 9'd3, 1'b0, 1'b0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b1);

    lineStart(9'd223, 1'b0, mk(1'b1, 1'b0, 9'd3, 1'b1, 8'd2));
    lineStart(9'd224, 1'b0, mk(1'b0, 1'b0, 9'd3, 1'b0, 8'd2));

    for (int k = 1; k <= 300; k++) begin
      int ovr;
      ovr = (k == 1) ? 2 : ((k + 1 > 255) ? 255 : k + 1);
      lineStart(9'd100, 1'b0, mk(1'(k % 2), 1'b1, 9'd101, k > 1, 8'(ovr)));
    end

    applyStimulus(9'h030, 9'd100, 1'b0, 1'b0, 1'b1, 8'h30, 11'h155, 1'b0, 1'b0);
    #3;
    RSTn = 1'b0;
    #1;
    checkOutput("midrst_rstart", 32'(RSTART), 32'd0);
    checkOutput("midrst_rline", 32'(RLINE), 32'd0);
    checkOutput("midrst_bank", 32'(BANK), 32'd0);
    checkOutput("midrst_rdat", 32'(RDAT), 32'd0);
    checkOutput("midrst_late", 32'(LATE), 32'd0);
    checkOutput("midrst_ovrcnt", 32'(OVRCNT), 32'd0);
    WE = 1'b0;
    HBLK = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    RSTn = 1'b1;
    repeat (4) applyStimulus(9'h000, 9'd5, 1'b1, 1'b0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b0);
    lineStart(9'd5, 1'b0, mk(1'b1, 1'b1, 9'd6, 1'b0, 8'd0));
    applyStimulus(9'h000, 9'd5, 1'b0, 1'b0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b0);

    for (int i = 0; i < 10 && (ls_q.size() != 0 || rd_q.size() != 0); i++) @(negedge PCLK);
    while (ls_q.size() != 0) begin
      void'(ls_q.pop_front());
      checks++;
      errors++;
      $display("[TB] FAIL ls_pending: got no swap expected a line-start swap");
    end
    while (rd_q.size() != 0) begin
      void'(rd_q.pop_front());
      checks++;
      errors++;
      $display("[TB] FAIL rdat_pending: got no readout expected a checked readout");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
